// File: rtl/acc_pkg.sv
// acc_pkg: opcode constants and FSM state encoding shared by the accumulator sequencer.
package acc_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_ALU, ST_FINISH} state_t;

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_ADDI   = 3'b001;
    localparam logic [2:0] OP_ADDR   = 3'b010;
    localparam logic [2:0] OP_ADDALU = 3'b011;
    localparam logic [2:0] OP_CLR    = 3'b100;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= OP_CLR;
    endfunction
endpackage

// File: rtl/acc_timeout_cnt.sv
// acc_timeout_cnt: counts cycles spent waiting on the ALU and flags when the limit is hit.
module acc_timeout_cnt #(
    parameter logic [7:0] TIMEOUT = 8'd200
) (
    input  logic CLK,
    input  logic CLB,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    logic [7:0] cnt_q, cnt_d;

    always_comb cnt_d = clr_i ? 8'd0 : en_i ? cnt_q + 8'd1 : cnt_q;

    always_ff @(posedge CLK or posedge CLB) begin
        if (CLB) cnt_q <= 8'd0;
        else     cnt_q <= cnt_d;
    end

    // Fires on the TIMEOUT-th waiting cycle, so the wait lasts exactly TIMEOUT cycles.
    assign expired_o = en_i && (cnt_q == TIMEOUT - 8'd1);
endmodule

// File: rtl/acc_sequencer.sv
// acc_sequencer: steps an external accumulator through repeated immediate, register
// and ALU adds, clears, and ALU-timeout aborts, one instruction at a time.
module acc_sequencer
    import acc_pkg::*;
#(
    parameter logic [7:0] TIMEOUT = 8'd200
) (
    input  logic       CLK,
    input  logic       CLB,
    input  logic       InstrValid,
    input  logic [2:0] InstrOp,
    input  logic [3:0] InstrRep,
    output logic       InstrReady,
    output logic       AluStart,
    input  logic       AluDone,
    output logic       LoadAcc,
    output logic       SelAcc0,
    output logic       SelAcc1,
    output logic       AccClr,
    output logic       Busy,
    output logic       Done,
    output logic       Err
);
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] op_q, op_d;
    logic       err_q, err_d;
    logic       sel0_q, sel0_d;
    logic       sel1_q, sel1_d;
    logic       expired;

    acc_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
        .CLK      (CLK),
        .CLB      (CLB),
        .clr_i    (state_q != ST_WAIT_ALU),
        .en_i     (state_q == ST_WAIT_ALU),
        .expired_o(expired)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        err_d    = err_q;
        sel0_d   = sel0_q;
        LoadAcc  = 1'b0;
        AccClr   = 1'b0;
        AluStart = 1'b0;
        case (state_q)
            ST_IDLE: if (InstrValid) begin
                op_d   = InstrOp;
                cnt_d  = InstrRep;
                sel0_d = (InstrOp == OP_ADDR);
                if (op_legal(InstrOp)) state_d = ST_ISSUE;
                else begin
                    err_d   = 1'b1;
                    state_d = ST_FINISH;
                end
            end
            ST_ISSUE: begin
                if (op_q == OP_ADDI || op_q == OP_ADDR) begin
                    LoadAcc = 1'b1;
                    if (cnt_q == 4'd0) state_d = ST_FINISH;
                    else               cnt_d   = cnt_q - 4'd1;
                end else if (op_q == OP_ADDALU) begin
                    AluStart = 1'b1;
                    state_d  = ST_WAIT_ALU;
                end else begin
                    AccClr  = (op_q == OP_CLR);
                    state_d = ST_FINISH;
                end
            end
            ST_WAIT_ALU: begin
                if (AluDone) begin
                    LoadAcc = 1'b1;
                    if (cnt_q == 4'd0) state_d = ST_FINISH;
                    else begin
                        cnt_d   = cnt_q - 4'd1;
                        state_d = ST_ISSUE;
                    end
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = ST_FINISH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Registered so the mux select is already stable when LoadAcc rises in WAIT_ALU.
        sel1_d = (state_d == ST_WAIT_ALU);
    end

    always_ff @(posedge CLK or posedge CLB) begin
        if (CLB) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            op_q    <= OP_NOP;
            err_q   <= 1'b0;
            sel0_q  <= 1'b0;
            sel1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            err_q   <= err_d;
            sel0_q  <= sel0_d;
            sel1_q  <= sel1_d;
        end
    end

    assign InstrReady = (state_q == ST_IDLE);
    assign Busy       = (state_q != ST_IDLE);
    assign Done       = (state_q == ST_FINISH);
    assign Err        = err_q;
    assign SelAcc0    = sel0_q;
    assign SelAcc1    = sel1_q;
endmodule

// File: doc/acc_sequencer.md
ACC_SEQUENCER -- requirements
Module: acc_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8'd200, meaning the maximum number of cycles spent in WAIT_ALU before abort.
REQ-002 SHALL have port CLK, input, 1 bit: the single system clock, rising edge.
REQ-003 SHALL have port CLB, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port InstrValid, input, 1 bit: an instruction is offered.
REQ-005 SHALL have port InstrOp, input, 3 bits: opcode, with 000 NOP, 001 ADDI, 010 ADDR, 011 ADDALU, 100 CLR, and 101-111 illegal.
REQ-006 SHALL have port InstrRep, input, 4 bits: repeat count; the number of adds executed is InstrRep+1.
REQ-007 SHALL have port InstrReady, output, 1 bit: the sequencer accepts an instruction this cycle.
REQ-008 SHALL have port AluStart, output, 1 bit: one-cycle request to the ALU.
REQ-009 SHALL have port AluDone, input, 1 bit: the ALU result is valid on B_AULOut.
REQ-010 SHALL have port LoadAcc, output, 1 bit: accumulator add-enable.
REQ-011 SHALL have port SelAcc0, output, 1 bit: 0 selects the immediate, 1 selects the register operand.
REQ-012 SHALL have port SelAcc1, output, 1 bit: 0 selects the SelAcc0 mux output, 1 selects the ALU output.
REQ-013 SHALL have port AccClr, output, 1 bit: accumulator clear request.
REQ-014 SHALL have port Busy, output, 1 bit: the state is not IDLE.
REQ-015 SHALL have port Done, output, 1 bit: one-cycle pulse when an instruction completes.
REQ-016 SHALL have port Err, output, 1 bit: sticky flag set by an illegal opcode or a timeout.

Function
REQ-017 SHALL implement the states IDLE, ISSUE, WAIT_ALU and FINISH.
REQ-018 SHALL drive InstrReady=1 only in IDLE; an instruction is accepted when InstrValid and InstrReady are both 1 on a rising edge.
REQ-019 SHALL, on acceptance, latch InstrOp, load the repeat counter with InstrRep, and go to ISSUE; an illegal opcode instead sets Err and goes to FINISH.
REQ-020 SHALL, for NOP, go ISSUE->FINISH with no LoadAcc and no AccClr asserted.
REQ-021 SHALL, for CLR, assert AccClr for exactly one cycle in ISSUE, ignore the repeat count, then go to FINISH.
REQ-022 SHALL, for ADDI or ADDR, assert LoadAcc=1 with SelAcc1=0 each ISSUE cycle, with SelAcc0=0 for ADDI and SelAcc0=1 for ADDR.
REQ-023 SHALL, for ADDI or ADDR, decrement the counter after each add and go to FINISH on the cycle the count reaches zero, giving InstrRep+1 consecutive LoadAcc cycles.
REQ-024 SHALL, for ADDALU in ISSUE, pulse AluStart for one cycle and go to WAIT_ALU.
REQ-025 SHALL, in WAIT_ALU, assert LoadAcc=1 with SelAcc1=1 on the cycle AluDone=1, then return to ISSUE if the count is nonzero (decrementing it) or go to FINISH if it is zero.
REQ-026 SHALL, if AluDone is asserted in the same cycle as AluStart, ignore it; only AluDone seen in WAIT_ALU counts.
REQ-027 SHALL, if AluDone stays low for TIMEOUT cycles in WAIT_ALU, set Err, issue no LoadAcc, and go to FINISH.
REQ-028 SHALL, in FINISH, pulse Done for one cycle and return to IDLE; the next instruction can be accepted no earlier than the following cycle.
REQ-029 SHALL hold LoadAcc, AccClr and AluStart low in every state and condition not listed above.
REQ-030 SHALL drive SelAcc0 and SelAcc1 from registers, so they are stable for the whole cycle in which LoadAcc is high.
REQ-031 SHALL never assert LoadAcc and AccClr in the same cycle.
REQ-032 SHALL clear Err only by reset.

Reset
REQ-033 SHALL, while CLB=1, immediately force the state to IDLE and clear the counter, the timeout counter and the latched opcode.
REQ-034 SHALL, while CLB=1, force LoadAcc, AccClr, AluStart, SelAcc0, SelAcc1, Done, Busy and Err to 0.
REQ-035 SHALL, when CLB is asserted in the middle of an operation, abort it with no further LoadAcc pulse; the first acceptance after release starts clean.

Structure
REQ-036 SHALL define the opcode constants and the state encoding in a shared package, acc_pkg.
REQ-037 SHALL place the WAIT_ALU timeout in one sub-module, acc_timeout_cnt, which has a clear input, an enable input and an expired output.

Verification
REQ-038 SHALL cover: ADDI, Rep=3 -> LoadAcc high for exactly 4 consecutive cycles, SelAcc0=0, SelAcc1=0, then Done 1 cycle later.
REQ-039 SHALL cover: ADDALU, Rep=1, AluDone returned 3 cycles after each AluStart -> 2 AluStart pulses and 2 LoadAcc pulses, each coincident with AluDone and with SelAcc1=1.
REQ-040 SHALL cover: ADDALU with AluDone never asserted -> Err=1 after 200 cycles in WAIT_ALU, no LoadAcc, Done pulsed, InstrReady back to 1.
REQ-041 SHALL cover: InstrOp=110 -> Err=1, no LoadAcc, no AccClr, Done pulsed; a following CLR still executes with AccClr high for 1 cycle.
REQ-042 SHALL cover: CLB pulsed during the third LoadAcc of ADDR, Rep=7 -> all outputs 0 at once, state IDLE, no further LoadAcc.
REQ-043 SHALL cover: InstrValid held high back-to-back with NOP then ADDR, Rep=0 -> second accepted only after Done, exactly one LoadAcc with SelAcc0=1.
